// File: rtl/n_mem_loader_pkg.sv
// rtl/n_mem_loader_pkg.sv - shared modulus memory geometry and loader state encoding
package n_mem_loader_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 7;
  localparam int TOTAL_ADDR = 128;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/n_mem_loader_if.sv
// rtl/n_mem_loader_if.sv - source word stream and N RAM port bundle for the loader
interface n_mem_loader_if;
  import n_mem_loader_pkg::*;

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] user_addr;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_wren;
  logic [DATA_WIDTH-1:0] mem_q;

  // Loader side: consumes the stream, drives the RAM.
  modport slave (
    input  in_valid, in_data, user_addr, mem_q,
    output in_ready, mem_address, mem_data, mem_wren
  );

  // Environment side: word source, consumer address and the RAM itself.
  modport master (
    output in_valid, in_data, user_addr, mem_q,
    input  in_ready, mem_address, mem_data, mem_wren
  );

endinterface

// File: rtl/n_mem_loader.sv
// rtl/n_mem_loader.sv - streams N into the modulus RAM; read-back check under N_MEM_LOADER_VERIFY_EN
module n_mem_loader
  import n_mem_loader_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  n_mem_loader_if.slave       bus,
  output logic                busy,
  output logic                done,
  output logic [ADDR_WIDTH:0] word_count,
  output logic                verify_err
);

  localparam logic [ADDR_WIDTH:0] LAST_WORD  = (ADDR_WIDTH+1)'(TOTAL_ADDR - 1);
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(TOTAL_ADDR);

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  wr_en_q;
  logic                  accept;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] int_addr;

`ifdef N_MEM_LOADER_VERIFY_EN
  logic [DATA_WIDTH-1:0] xor_w;
  logic [DATA_WIDTH-1:0] xor_r;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH:0]   rd_cnt;
  logic                  rd_p1;
  logic                  rd_p2;
  logic                  last_p1;
  logic                  last_p2;

  // A pending write always owns the port; reads only go out on idle write cycles.
  assign int_addr = wr_en_q ? wr_addr_q : rd_addr;
`else
  assign int_addr   = wr_addr_q;
  assign verify_err = 1'b0;
`endif

  assign bus.in_ready    = (state == ST_LOAD);
  assign accept          = bus.in_valid & (state == ST_LOAD);
  assign busy            = (state != ST_IDLE) & (state != ST_DONE);
  // The consumer keeps the port until the final write has left the pipeline.
  assign sel_wr          = (state == ST_LOAD) | (state == ST_VERIFY) | wr_en_q;
  assign bus.mem_address = sel_wr ? int_addr : bus.user_addr;
  assign bus.mem_wren    = wr_en_q;
  assign bus.mem_data    = wr_data_q;

  // Load FSM: accepts words, registers one write per accept, then (optionally) re-reads the image.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      done       <= 1'b0;
      word_count <= '0;
`ifdef N_MEM_LOADER_VERIFY_EN
      xor_w      <= '0;
      xor_r      <= '0;
      rd_addr    <= '0;
      rd_cnt     <= '0;
      rd_p1      <= 1'b0;
      rd_p2      <= 1'b0;
      last_p1    <= 1'b0;
      last_p2    <= 1'b0;
      verify_err <= 1'b0;
`endif
    end else begin
      wr_en_q <= 1'b0;
`ifdef N_MEM_LOADER_VERIFY_EN
      // Two-stage tag pipeline matching the RAM's address-to-q latency.
      rd_p1   <= 1'b0;
      last_p1 <= 1'b0;
      rd_p2   <= rd_p1;
      last_p2 <= last_p1;
`endif
      case (state)
        ST_IDLE, ST_DONE: begin
          // done rises one cycle after the last write has been issued.
          if (state == ST_DONE) done <= 1'b1;
          if (start) begin
            state      <= ST_LOAD;
            word_count <= '0;
            done       <= 1'b0;
`ifdef N_MEM_LOADER_VERIFY_EN
            xor_w      <= '0;
            xor_r      <= '0;
            rd_addr    <= '0;
            rd_cnt     <= '0;
            verify_err <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          if (accept && (word_count != FULL_COUNT)) begin
            wr_addr_q  <= word_count[ADDR_WIDTH-1:0];
            wr_data_q  <= bus.in_data;
            wr_en_q    <= 1'b1;
            word_count <= word_count + 1'b1;
`ifdef N_MEM_LOADER_VERIFY_EN
            xor_w      <= xor_w ^ bus.in_data;
            if (word_count == LAST_WORD) state <= ST_VERIFY;
`else
            if (word_count == LAST_WORD) state <= ST_DONE;
`endif
          end
        end
`ifdef N_MEM_LOADER_VERIFY_EN
        ST_VERIFY: begin
          if (!wr_en_q && (rd_cnt != FULL_COUNT)) begin
            rd_addr <= rd_addr + 1'b1;
            rd_cnt  <= rd_cnt + 1'b1;
            rd_p1   <= 1'b1;
            last_p1 <= (rd_cnt == LAST_WORD);
          end
          if (rd_p2) begin
            xor_r <= xor_r ^ bus.mem_q;
            if (last_p2) begin
              verify_err <= ((xor_r ^ bus.mem_q) != xor_w);
              done       <= 1'b1;
              state      <= ST_DONE;
            end
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/n_mem_loader.md
Name: n_mem_loader

Overview:
- Runtime writer for the modulus memory. Streams N into a writable single-port N RAM instead of relying on a preloaded init file.
- Accepts DATA_WIDTH-bit words over a valid/ready handshake and writes them to consecutive addresses 0..TOTAL_ADDR-1.
- Asserts done after the last write.
- Outside a load, passes the ModExp datapath's read address straight through to the memory, so read latency is unchanged for the consumer.

Parameters:
- DATA_WIDTH, 32: memory word width; matches the shared `DATA_WIDTH.
- ADDR_WIDTH, 7: memory address width; matches the shared `ADDR_WIDTH.
- TOTAL_ADDR, 128: words per modulus (4096/32); matches the shared `TOTAL_ADDR.

Ports:
- clock  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins a load from IDLE or DONE.
- in_valid  in  1  source word valid.
- in_data  in  DATA_WIDTH  source word; word k goes to address k.
- in_ready  out  1  loader accepts in_data this cycle.
- user_addr  in  ADDR_WIDTH  consumer read address, used when not loading.
- mem_address  out  ADDR_WIDTH  to the RAM address port.
- mem_data  out  DATA_WIDTH  to the RAM data port.
- mem_wren  out  1  to the RAM write enable.
- mem_q  in  DATA_WIDTH  RAM registered read data; 2-cycle address-to-q latency.
- busy  out  1  load (or verify) in progress.
- done  out  1  full modulus resident.
- word_count  out  ADDR_WIDTH+1  number of words accepted in the current load.
- verify_err  out  1  read-back mismatch; see Optional Feature.

Behaviour:
- Interface decided: one clock, named clock; reset named reset, synchronous and active-high.
- Reset values: state=IDLE, in_ready=0, mem_wren=0, busy=0, done=0, word_count=0, verify_err=0, write registers cleared. Reset mid-load aborts immediately; any partial image is discarded; done stays 0.
- States: IDLE, LOAD, VERIFY (macro only), DONE.
- IDLE/DONE:
  - start=1 -> LOAD; word_count=0; done=0 on the next cycle.
  - start is ignored in LOAD and VERIFY.
- LOAD:
  - in_ready = (state==LOAD), combinational.
  - Accept = in_valid & in_ready.
  - On accept, register wr_addr_q=word_count[ADDR_WIDTH-1:0], wr_data_q=in_data, wr_en_q=1, and increment word_count.
  - Write reaches the RAM one cycle after accept. Back-to-back accepts give one write per cycle.
  - in_valid low: no write, no count change.
  - Accept while word_count==TOTAL_ADDR-1 -> DONE (or VERIFY). in_ready drops the following cycle. No extra words are ever accepted.
- Memory mux:
  - sel_wr = (state==LOAD) | (state==VERIFY) | wr_en_q.
  - mem_address = sel_wr ? internal address : user_addr, combinational.
  - mem_wren = wr_en_q; mem_data = wr_data_q.
  - The last write issues in the first DONE cycle. done asserts one cycle after that write, so the consumer never races the final write.
- busy = (state!=IDLE) & (state!=DONE).
- done is held until the next start or reset.
- word_count saturates at TOTAL_ADDR; the address does not wrap.

Optional Feature:
- Macro: N_MEM_LOADER_VERIFY_EN.
- With the macro:
  - LOAD keeps xor_w = XOR of all accepted words.
  - After the last write, the block enters VERIFY and issues reads at addresses 0..TOTAL_ADDR-1, one per cycle.
  - It folds mem_q, sampled 2 cycles after each address, into xor_r.
  - After the final sample: verify_err = (xor_r != xor_w); state -> DONE.
  - done asserts together with verify_err.
- Without the macro: no VERIFY state, verify_err tied 0, checksum logic absent.

Decomposition:
- Shared package/include (existing _parameter.v): DATA_WIDTH, ADDR_WIDTH, TOTAL_ADDR, and the state encoding localparams (ST_IDLE, ST_LOAD, ST_VERIFY, ST_DONE).
- Optional sub-module n_mem_ram: the writable altsyncram wrapper, identical to the ROM wrapper except wren is a port and there is no init file. The loader itself is one flat module.

Test Plan:
- Contiguous load: start, then 128 words 0x1000_0000+k with in_valid held 1 -> writes addr k=data k on consecutive cycles; done=1 exactly 2 cycles after the last accept; word_count=128.
- Gapped source: in_valid toggles 1,0,0,1 pattern -> writes only on accept cycles; addresses stay contiguous; no duplicate writes.
- Reset mid-load: reset at word 40 -> the next cycle shows IDLE, mem_wren=0, word_count=0, done=0; a following start reloads from addr 0.
- start pulsed during LOAD at word 10 -> ignored; word_count continues 11,12,...
- Passthrough: in DONE, user_addr=0x05 -> mem_address=0x05 in the same cycle; mem_wren=0.
- VERIFY_EN: model returns a corrupted word at addr 77 -> verify_err=1 with done; a clean model gives verify_err=0.
